// File: rtl/hammu_hamnhan_sequencer.sv
// hammu_hamnhan_sequencer: arbitrates two requesters onto one AXI4-Lite hammu_hamnhan_ip and runs write/poll/read jobs
`timescale 1ns/1ps
module hammu_hamnhan_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h7c800000,
  parameter int          POLL_MAX  = 256,
  parameter int          CNT_W     = 9
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_mode,
  input  logic        req1_mode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RA, S_RR, S_DONE} state_t;
  state_t           r_state;
  logic             r_last;
  logic             r_mode;
  logic             r_res;
  logic [31:0]      r_b;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_poll;
  logic             w_req;
  logic             w_gnt;
  logic             w_aw_ok;
  logic             w_w_ok;
  logic [CNT_W-1:0] w_poll_nxt;
  assign w_req       = req0_valid | req1_valid;
  assign w_gnt       = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_aw_ok     = ~M_AXI_AWVALID | M_AXI_AWREADY;
  assign w_w_ok      = ~M_AXI_WVALID | M_AXI_WREADY;
  assign w_poll_nxt  = r_poll + 1'b1;
  assign M_AXI_WSTRB = 4'hF;
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_mode        <= 1'b0;
      r_res         <= 1'b0;
      r_b           <= '0;
      r_idx         <= '0;
      r_poll        <= '0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_req) begin
          req0_ready    <= ~w_gnt;
          req1_ready    <= w_gnt;
          r_last        <= w_gnt;
          rsp_id        <= w_gnt;
          r_mode        <= w_gnt ? req1_mode : req0_mode;
          r_b           <= w_gnt ? req1_b : req0_b;
          r_idx         <= '0;
          r_poll        <= '0;
          busy          <= 1'b1;
          rsp_data      <= '0;
          rsp_err       <= 1'b0;
          M_AXI_AWADDR  <= BASE_ADDR + 32'h4;
          M_AXI_WDATA   <= w_gnt ? req1_a : req0_a;
          M_AXI_AWVALID <= 1'b1;
          M_AXI_WVALID  <= 1'b1;
          r_state       <= S_WR;
        end
        S_WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            M_AXI_BREADY <= 1'b1;
            r_state      <= S_WRESP;
          end
        end
        S_WRESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_idx == 2'd2) begin
            M_AXI_ARADDR  <= BASE_ADDR + 32'hC;
            M_AXI_ARVALID <= 1'b1;
            r_res         <= 1'b0;
            r_state       <= S_RA;
          end else begin
            r_idx         <= r_idx + 2'd1;
            M_AXI_AWADDR  <= (r_idx == 2'd0) ? BASE_ADDR + 32'h8 : BASE_ADDR;
            M_AXI_WDATA   <= (r_idx == 2'd0) ? r_b : {30'b0, r_mode, 1'b1};
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            r_state       <= S_WR;
          end
        end
        S_RA: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b1;
          r_state       <= S_RR;
        end
        S_RR: if (M_AXI_RVALID) begin
          M_AXI_RREADY <= 1'b0;
          if (M_AXI_RRESP != 2'b00) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_res) begin
            rsp_data  <= M_AXI_RDATA;
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (M_AXI_RDATA[0]) begin
            M_AXI_ARADDR  <= BASE_ADDR + 32'h10;
            M_AXI_ARVALID <= 1'b1;
            r_res         <= 1'b1;
            r_state       <= S_RA;
          end else if (w_poll_nxt == CNT_W'(POLL_MAX)) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_poll        <= w_poll_nxt;
            M_AXI_ARVALID <= 1'b1;
            r_state       <= S_RA;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hammu_hamnhan_sequencer.sv
// tb_hammu_hamnhan_sequencer: randomized scoreboard bench with an AXI4-Lite slave model of hammu_hamnhan_ip
`timescale 1ns/1ps
module tb_hammu_hamnhan_sequencer;
  localparam int          PM   = 4;
  localparam logic [31:0] BASE = 32'h7c800000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready, req0_mode = 0, req1_mode = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [31:0] M_AXI_RDATA = 0;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP = 0, M_AXI_RRESP = 0;
  logic M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic M_AXI_AWREADY = 0, M_AXI_WREADY = 0, M_AXI_BVALID = 0, M_AXI_ARREADY = 0, M_AXI_RVALID = 0;

  always #5 clk = ~clk;

  hammu_hamnhan_sequencer #(.BASE_ADDR(BASE), .POLL_MAX(PM), .CNT_W(9)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mode(req0_mode), .req1_mode(req1_mode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int errors = 0;
  int checks = 0;
  int cfg_done_after = 1;
  int cfg_berr_k = -1;
  int cfg_dly = 0;
  int cfg_bfix = -1;

  typedef struct {
    bit          id;
    bit          mode;
    logic [31:0] a, b, data;
    bit          err;
    int          nwr, nstat, nres, wbase, rbase;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] wa_log[$], wd_log[$], ra_log[$];
  logic [31:0] s_opa = 0, s_opb = 0, s_res = 0;
  int s_polls = 0;
  logic [1:0] v_edge = 0;

  always @(posedge clk) v_edge <= {req1_valid, req0_valid};

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic int dly();
    return cfg_dly == 0 ? 0 : int'($urandom_range(cfg_dly, 0));
  endfunction

  function automatic logic [31:0] xpow(logic [31:0] a, logic [31:0] b);
    logic [31:0] r = 1;
    for (int i = 0; i < int'(b); i++) r = r * a;
    return r;
  endfunction

  // Reference: outcome of a whole job from the slave configuration alone
  function automatic exp_t model(bit id, bit mode, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.id = id; e.mode = mode; e.a = a; e.b = b;
    e.data = 0; e.err = 1; e.nstat = 0; e.nres = 0; e.nwr = 3; e.wbase = 0; e.rbase = 0;
    if (cfg_berr_k >= 0) e.nwr = cfg_berr_k + 1;
    else if (cfg_done_after < 1 || cfg_done_after > PM) e.nstat = PM;
    else begin
      e.nstat = cfg_done_after; e.nres = 1; e.err = 0;
      e.data = mode ? a * b : xpow(a, b);
    end
    return e;
  endfunction

  task automatic slave_write();
    logic [31:0] a = 0, d = 0;
    int da = dly(), dw = dly(), bd, g = 0, k;
    bit ga = 0, gw = 0;
    logic [1:0] br;
    while (!(ga && gw)) begin
      M_AXI_AWREADY = !ga && M_AXI_AWVALID && da == 0;
      M_AXI_WREADY  = !gw && M_AXI_WVALID && dw == 0;
      if (M_AXI_AWREADY) begin a = M_AXI_AWADDR; ga = 1; end else if (!ga && da > 0) da--;
      if (M_AXI_WREADY) begin d = M_AXI_WDATA; gw = 1; end else if (!gw && dw > 0) dw--;
      @(negedge clk);
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
      if (rst) return;
      if (++g > 1000) begin chk("aw_w_timeout", 0, 1); return; end
    end
    wa_log.push_back(a); wd_log.push_back(d);
    if (a == BASE + 32'h4) s_opa = d;
    else if (a == BASE + 32'h8) s_opb = d;
    else if (a == BASE && d[0]) begin s_res = d[1] ? s_opa * s_opb : s_opa ** s_opb; s_polls = 0; end
    k = a == BASE + 32'h4 ? 0 : a == BASE + 32'h8 ? 1 : 2;
    br = (cfg_berr_k == k) ? 2'b10 : 2'b00;
    bd = cfg_bfix >= 0 ? cfg_bfix : dly();
    repeat (bd) begin @(negedge clk); if (rst) return; end
    M_AXI_BVALID = 1; M_AXI_BRESP = br; g = 0;
    while (!M_AXI_BREADY) begin
      @(negedge clk);
      if (rst || ++g > 1000) begin
        if (!rst) chk("b_timeout", 0, 1);
        M_AXI_BVALID = 0; M_AXI_BRESP = 0; return;
      end
    end
    @(negedge clk);
    M_AXI_BVALID = 0; M_AXI_BRESP = 0;
  endtask

  task automatic slave_read();
    logic [31:0] a;
    int g = 0;
    repeat (dly()) begin @(negedge clk); if (rst) return; end
    M_AXI_ARREADY = 1; a = M_AXI_ARADDR;
    @(negedge clk);
    M_AXI_ARREADY = 0;
    if (rst) return;
    ra_log.push_back(a);
    if (a == BASE + 32'hC) s_polls++;
    repeat (dly()) begin @(negedge clk); if (rst) return; end
    M_AXI_RVALID = 1; M_AXI_RRESP = 0;
    M_AXI_RDATA = a == BASE + 32'h10 ? s_res :
                  a == BASE + 32'hC ? {31'b0, cfg_done_after > 0 && s_polls >= cfg_done_after} : 32'hdeadbeef;
    while (!M_AXI_RREADY) begin
      @(negedge clk);
      if (rst || ++g > 1000) begin
        if (!rst) chk("r_timeout", 0, 1);
        M_AXI_RVALID = 0; return;
      end
    end
    @(negedge clk);
    M_AXI_RVALID = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
    end else if (M_AXI_AWVALID || M_AXI_WVALID) slave_write();
    else if (M_AXI_ARVALID) slave_read();
  end

  // Monitor: protocol rules, grant order, and scoreboard pop on each response
  initial begin
    exp_t e;
    bit g, m_last = 1;
    bit p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
    logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0, ea, ed;
    int nw, ns, nr, nb;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        exp_q.delete(); m_last = 1; p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw && !p_awr) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR == p_awa}, 2'b11);
        if (p_w && !p_wr) chk("w_hold", {M_AXI_WVALID, M_AXI_WDATA == p_wd}, 2'b11);
        if (p_ar && !p_arr) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR == p_ara}, 2'b11);
        if (M_AXI_ARVALID) chk("ar_excl", M_AXI_AWVALID | M_AXI_WVALID, 0);
        p_aw = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awa = M_AXI_AWADDR;
        p_w = M_AXI_WVALID; p_wr = M_AXI_WREADY; p_wd = M_AXI_WDATA;
        p_ar = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_ara = M_AXI_ARADDR;
        if (req0_ready || req1_ready) begin
          g = v_edge == 2'b11 ? !m_last : v_edge[1];
          chk("grant", {req1_ready, req0_ready}, g ? 2 : 1);
          chk("grant_req", v_edge != 0, 1);
          chk("grant_idle", exp_q.size(), 0);
          m_last = g;
          e = g ? model(1, req1_mode, req1_a, req1_b) : model(0, req0_mode, req0_a, req0_b);
          e.wbase = wa_log.size(); e.rbase = ra_log.size();
          exp_q.push_back(e);
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_busy", busy, 1);
            nw = wa_log.size() - e.wbase;
            chk("n_writes", nw, e.nwr);
            for (int k = 0; k < nw && k < 3; k++) begin
              ea = k == 0 ? BASE + 32'h4 : k == 1 ? BASE + 32'h8 : BASE;
              ed = k == 0 ? e.a : k == 1 ? e.b : {30'b0, e.mode, 1'b1};
              chk("wr_addr", wa_log[e.wbase + k], ea);
              chk("wr_data", wd_log[e.wbase + k], ed);
            end
            ns = 0; nr = 0; nb = 0;
            for (int k = e.rbase; k < ra_log.size(); k++)
              if (ra_log[k] == BASE + 32'hC) ns++; else if (ra_log[k] == BASE + 32'h10) nr++; else nb++;
            chk("n_status", ns, e.nstat);
            chk("n_result", nr, e.nres);
            chk("rd_addr_bad", nb, 0);
          end
        end
      end
    end
  end

  task automatic run(bit v0, bit v1, bit m0, logic [31:0] a0, logic [31:0] b0,
                     bit m1, logic [31:0] a1, logic [31:0] b1);
    int t = 0;
    @(negedge clk); #2;
    req0_mode = m0; req0_a = a0; req0_b = b0; req1_mode = m1; req1_a = a1; req1_b = b1;
    req0_valid = v0; req1_valid = v1;
    while ((req0_valid || req1_valid || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk); #2;
      if (req0_ready) req0_valid = 0;
      if (req1_ready) req1_valid = 0;
      t++;
    end
    if (t >= 5000) begin
      chk("job_timeout", t, 0);
      req0_valid = 0; req1_valid = 0;
    end
  endtask

  initial begin
    int t;
    bit m0, m1;
    logic [1:0] v;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", M_AXI_AWVALID, 0);
    chk("rst_wvalid", M_AXI_WVALID, 0);
    chk("rst_bready", M_AXI_BREADY, 0);
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_wstrb", M_AXI_WSTRB, 4'hF);
    chk("rst_rsp", {rsp_valid, rsp_err, busy, req0_ready, req1_ready}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk); rst = 0;
    cfg_done_after = 1;
    run(1, 1, 0, 5, 3, 1, 7, 6);
    cfg_done_after = 2;
    run(1, 0, 0, 3, 4, 0, 0, 0);
    run(1, 1, 1, 9, 9, 1, 7, 6);
    run(1, 1, 0, 2, 5, 1, 11, 13);
    cfg_done_after = PM;
    run(0, 1, 1, 32'hffffffff, 32'h2, 0, 3, 3);
    cfg_dly = 5;
    for (int i = 0; i < 20; i++) begin
      v = 2'($urandom_range(3, 1));
      m0 = 1'($urandom_range(1, 0)); m1 = 1'($urandom_range(1, 0));
      cfg_done_after = $urandom_range(3, 1);
      run(v[0], v[1], m0, $urandom, m0 ? $urandom : $urandom_range(12, 0),
          m1, $urandom, m1 ? $urandom : $urandom_range(12, 0));
    end
    cfg_done_after = 0;
    run(1, 0, 1, 6, 7, 0, 0, 0);
    cfg_dly = 0;
    run(1, 1, 0, 2, 2, 1, 3, 3);
    cfg_done_after = 1;
    cfg_berr_k = 1;
    run(0, 1, 0, 0, 0, 1, 8, 8);
    cfg_berr_k = -1;
    run(1, 0, 1, 12, 12, 0, 0, 0);
    cfg_bfix = 10;
    @(negedge clk); #2;
    req0_mode = 1; req0_a = 5; req0_b = 5; req0_valid = 1;
    t = 0;
    while (!M_AXI_BREADY && t < 200) begin
      @(negedge clk); #2;
      if (req0_ready) req0_valid = 0;
      t++;
    end
    chk("reach_wresp", M_AXI_BREADY, 1);
    req0_valid = 0;
    #1 rst = 1;
    #1;
    chk("async_awvalid", M_AXI_AWVALID, 0);
    chk("async_wvalid", M_AXI_WVALID, 0);
    chk("async_bready", M_AXI_BREADY, 0);
    chk("async_ar_r", {M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("async_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 0; cfg_bfix = -1;
    run(0, 1, 0, 0, 0, 0, 2, 10);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
